// File: rtl/apb4_wait_mem_slave_if.sv
// APB4 bus bundle between a master and the wait-state memory slave.
// pclk/presetn stay outside the bundle as plain ports.
interface apb4_wait_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic [2:0]                pprot;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_wait_mem_slave.sv
// APB4 memory slave with programmable wait states, byte strobes, error responses,
// two read-only status words (ID and saturating error count).
module apb4_wait_mem_slave #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 2**ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RO_BASE    = 'h10,
  parameter logic [15:0]           ID_VALUE   = 16'hA5B4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb4_wait_mem_slave_if.slave  apb,
  input  logic [3:0]            wait_cfg,
  output logic [7:0]            err_count
);

  localparam int                    STRB_W  = DATA_WIDTH/8;
  localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] RO_NEXT = RO_BASE + 1'b1;
  localparam logic [DATA_WIDTH-1:0] ID_D    = DATA_WIDTH'(ID_VALUE);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_q;
  logic                    priv_q;
  logic [3:0]              waitCnt_q;
  logic [DATA_WIDTH-1:0]   prdata_q;
  logic [7:0]              errCount_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [IDX_W-1:0]        idx;
  logic                    reqErr;
  logic                    completing;
  logic [DATA_WIDTH-1:0]   rdVal;
  logic [DATA_WIDTH-1:0]   memWord_d;

  assign idx        = IDX_W'(addr_q);
  assign completing = (state_q == ACCESS) && (waitCnt_q == 4'd0);

  // Error decision is made on the request captured at SETUP, not on live bus values.
  assign reqErr = ({1'b0, addr_q} >= DEPTH_L)
                || (write_q && ((addr_q == RO_BASE) || (addr_q == RO_NEXT)))
                || (write_q && !priv_q);

  always_comb begin
    rdVal = '0;
    if (!reqErr) begin
      if (addr_q == RO_BASE)      rdVal = ID_D;
      else if (addr_q == RO_NEXT) rdVal = DATA_WIDTH'(errCount_q);
      else                        rdVal = mem_q[idx];
    end
  end

  always_comb begin
    memWord_d = mem_q[idx];
    for (int b = 0; b < STRB_W; b++) begin
      if (strb_q[b]) memWord_d[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      priv_q     <= 1'b0;
      waitCnt_q  <= 4'd0;
      prdata_q   <= '0;
      errCount_q <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (apb.psel && !apb.penable) begin
            addr_q    <= apb.paddr;
            write_q   <= apb.pwrite;
            wdata_q   <= apb.pwdata;
            strb_q    <= apb.pstrb;
            priv_q    <= apb.pprot[0];
            waitCnt_q <= wait_cfg;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          // Losing psel/penable mid-transfer abandons it without side effects.
          if (!(apb.psel && apb.penable)) begin
            waitCnt_q <= 4'd0;
            state_q   <= IDLE;
          end else if (waitCnt_q != 4'd0) begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end else begin
            state_q  <= IDLE;
            prdata_q <= rdVal;
            if (reqErr) begin
              if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
            end else if (write_q) begin
              mem_q[idx] <= memWord_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is presented live in the completing cycle and held afterwards.
  assign apb.pready   = (state_q == IDLE) || (waitCnt_q == 4'd0);
  assign apb.pslverr  = completing && reqErr;
  assign apb.prdata   = completing ? rdVal : prdata_q;
  assign err_count    = errCount_q;

endmodule

// File: tb/tb_apb4_wait_mem_slave.sv
// Directed bench for apb4_wait_mem_slave: a word-level memory/error model predicts
// every cycle's outputs; literal expectations pin the key results.
module tb_apb4_wait_mem_slave;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 256;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [3:0] wait_cfg;
  logic [7:0] err_count;

  apb4_wait_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb();

  apb4_wait_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
    .RO_BASE(8'h10), .ID_VALUE(16'hA5B4)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .apb       (apb),
    .wait_cfg  (wait_cfg),
    .err_count (err_count)
  );

  always #5 pclk = ~pclk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] modelMem [DEPTH];
  int          modelCount;
  bit          checkEn, readyCheck, rdCheck;
  logic        expReady, expSlvErr;
  logic [15:0] expRdata;
  logic [15:0] gotRd;
  logic        gotErr;
  int          lowCycles;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < DEPTH; i++) modelMem[i] = 16'h0000;
    modelCount = 0;
  endtask

  // Cycle-by-cycle comparison against the model's current expectations.
  always @(negedge pclk) begin
    if (checkEn) begin
      if (readyCheck) checkOutput("pready", {31'd0, apb.pready}, {31'd0, expReady});
      checkOutput("pslverr", {31'd0, apb.pslverr}, {31'd0, expSlvErr});
      checkOutput("err_count", {24'd0, err_count}, modelCount);
      if (rdCheck) checkOutput("prdata", {16'd0, apb.prdata}, {16'd0, expRdata});
    end
  end

  task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [15:0] data,
                               input logic [1:0] strb, input logic [2:0] prot,
                               input logic [3:0] waitN, input int abortAfter);
    bit          isErr;
    logic [15:0] rdExp;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pstrb   = strb;
    apb.pprot   = prot;
    wait_cfg    = waitN;
    expReady    = 1'b1;
    expSlvErr   = 1'b0;
    rdCheck     = 1'b0;
    readyCheck  = 1'b1;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    wait_cfg    = ~waitN;
    lowCycles   = 0;
    for (int k = 0; k < int'(waitN); k++) begin
      if (k == abortAfter) begin
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        readyCheck  = 1'b0;
        @(posedge pclk); #1;
        expReady   = 1'b1;
        readyCheck = 1'b1;
        return;
      end
      expReady = 1'b0;
      #2;
      if (apb.pready === 1'b0) lowCycles++;
      @(posedge pclk); #1;
    end
    isErr = (int'(addr) >= DEPTH) || (wr && (addr == 8'h10 || addr == 8'h11)) || (wr && !prot[0]);
    if (isErr)              rdExp = 16'h0000;
    else if (addr == 8'h10) rdExp = 16'hA5B4;
    else if (addr == 8'h11) rdExp = 16'(modelCount);
    else                    rdExp = modelMem[addr];
    expReady  = 1'b1;
    expSlvErr = isErr;
    if (!wr) begin
      expRdata = rdExp;
      rdCheck  = 1'b1;
    end
    #2;
    gotRd  = apb.prdata;
    gotErr = apb.pslverr;
    @(posedge pclk); #1;
    if (isErr) begin
      if (modelCount < 255) modelCount++;
    end else if (wr) begin
      if (strb[0]) modelMem[addr][7:0]  = data[7:0];
      if (strb[1]) modelMem[addr][15:8] = data[15:8];
    end
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    rdCheck     = 1'b0;
    expSlvErr   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    presetn     = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;
    apb.pprot   = '0;
    wait_cfg    = 4'd0;
    checkEn     = 1'b0;
    readyCheck  = 1'b1;
    rdCheck     = 1'b0;
    expReady    = 1'b1;
    expSlvErr   = 1'b0;
    expRdata    = '0;
    resetModel();
    #12;
    checkOutput("rst_pready",  {31'd0, apb.pready},  32'd1);
    checkOutput("rst_pslverr", {31'd0, apb.pslverr}, 32'd0);
    checkOutput("rst_prdata",  {16'd0, apb.prdata},  32'd0);
    checkOutput("rst_errcnt",  {24'd0, err_count},   32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    checkEn = 1'b1;
    @(posedge pclk); #1;

    // Zero-wait write then read back.
    applyStimulus(1'b1, 8'h05, 16'h1234, 2'b11, 3'b001, 4'd0, -1);
    checkOutput("w05_lat", lowCycles, 32'd0);
    applyStimulus(1'b0, 8'h05, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r05_data", {16'd0, gotRd}, 32'h1234);
    checkOutput("r05_err",  {31'd0, gotErr}, 32'd0);

    // Three wait states each way.
    applyStimulus(1'b1, 8'h20, 16'hBEEF, 2'b11, 3'b001, 4'd3, -1);
    checkOutput("w20_wait", lowCycles, 32'd3);
    applyStimulus(1'b0, 8'h20, 16'h0000, 2'b11, 3'b001, 4'd3, -1);
    checkOutput("r20_wait", lowCycles, 32'd3);
    checkOutput("r20_data", {16'd0, gotRd}, 32'hBEEF);

    // Byte-lane strobes.
    applyStimulus(1'b1, 8'h07, 16'hFFFF, 2'b11, 3'b001, 4'd0, -1);
    applyStimulus(1'b1, 8'h07, 16'h0000, 2'b01, 3'b001, 4'd1, -1);
    applyStimulus(1'b0, 8'h07, 16'h0000, 2'b00, 3'b000, 4'd0, -1);
    checkOutput("r07_data", {16'd0, gotRd}, 32'hFF00);
    applyStimulus(1'b1, 8'h07, 16'hABCD, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("w07_nostrb_err", {31'd0, gotErr}, 32'd0);

    // Error responses and read-only words.
    applyStimulus(1'b1, 8'h10, 16'h9999, 2'b11, 3'b001, 4'd0, -1);
    checkOutput("w10_err", {31'd0, gotErr}, 32'd1);
    applyStimulus(1'b1, 8'h30, 16'h7777, 2'b11, 3'b000, 4'd2, -1);
    checkOutput("w30_err", {31'd0, gotErr}, 32'd1);
    applyStimulus(1'b0, 8'h30, 16'h0000, 2'b00, 3'b000, 4'd0, -1);
    checkOutput("r30_data", {16'd0, gotRd}, 32'h0000);
    applyStimulus(1'b0, 8'h11, 16'h0000, 2'b00, 3'b000, 4'd0, -1);
    checkOutput("r11_data", {16'd0, gotRd}, 32'h0002);
    applyStimulus(1'b0, 8'h10, 16'h0000, 2'b00, 3'b000, 4'd1, -1);
    checkOutput("r10_data", {16'd0, gotRd}, 32'hA5B4);

    // Abort during wait states.
    applyStimulus(1'b1, 8'h40, 16'h5555, 2'b11, 3'b001, 4'd5, 2);
    applyStimulus(1'b0, 8'h40, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r40_abort", {16'd0, gotRd}, 32'h0000);
    checkOutput("abort_errcnt", {24'd0, err_count}, 32'd2);

    // Stray penable in IDLE is ignored.
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    applyStimulus(1'b0, 8'h05, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r05_after_stray", {16'd0, gotRd}, 32'h1234);

    // Error counter saturation.
    for (int n = 0; n < 260; n++) begin
      applyStimulus(1'b1, 8'h10, 16'h1111, 2'b11, 3'b001, 4'd0, -1);
    end
    checkOutput("sat_errcnt", {24'd0, err_count}, 32'h00FF);
    applyStimulus(1'b0, 8'h11, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r11_sat", {16'd0, gotRd}, 32'h00FF);

    // Reset asserted in the middle of wait states.
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h40;
    apb.pwdata  = 16'h5555;
    apb.pstrb   = 2'b11;
    apb.pprot   = 3'b001;
    wait_cfg    = 4'd5;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    expReady    = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    checkEn = 1'b0;
    presetn = 1'b0;
    #1;
    checkOutput("midrst_pready", {31'd0, apb.pready}, 32'd1);
    checkOutput("midrst_errcnt", {24'd0, err_count}, 32'd0);
    checkOutput("midrst_prdata", {16'd0, apb.prdata}, 32'd0);
    resetModel();
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    expReady    = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b1;
    checkEn = 1'b1;
    @(posedge pclk); #1;
    applyStimulus(1'b0, 8'h40, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r40_postrst", {16'd0, gotRd}, 32'h0000);
    applyStimulus(1'b0, 8'h05, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r05_postrst", {16'd0, gotRd}, 32'h0000);
    applyStimulus(1'b0, 8'h11, 16'h0000, 2'b00, 3'b001, 4'd0, -1);
    checkOutput("r11_postrst", {16'd0, gotRd}, 32'h0000);

    @(posedge pclk); #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
